// File: rtl/simon_pkg.sv
// Shared colour codes, FSM encoding and colour decode for Simon playback.
// Used by simon_playback_ctrl and simon_tick_gen.
package simon_pkg;

    localparam logic [1:0] COL_RED    = 2'd0;
    localparam logic [1:0] COL_GREEN  = 2'd1;
    localparam logic [1:0] COL_BLUE   = 2'd2;
    localparam logic [1:0] COL_YELLOW = 2'd3;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_FETCH = 3'd1;
    localparam logic [2:0] ENC_ON    = 3'd2;
    localparam logic [2:0] ENC_GAP   = 3'd3;
    localparam logic [2:0] ENC_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_FETCH = ENC_FETCH,
        ST_ON    = ENC_ON,
        ST_GAP   = ENC_GAP,
        ST_DONE  = ENC_DONE
    } state_t;

    function automatic logic [3:0] col_onehot(input logic [1:0] col);
        col_onehot = 4'b0001 << col;
    endfunction

endpackage

// File: rtl/simon_tick_gen.sv
// Restartable clock-enable prescaler: one-cycle tick every TICK_DIV enabled cycles.
// clr has priority and holds the count at zero.
module simon_tick_gen
    import simon_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/simon_playback_ctrl.sv
// Plays the stored Simon pattern on four LEDs: timed ON phase then dark GAP per colour.
// Optional SIMON_SPEEDUP_EN: long sequences use a halved ON phase.
module simon_playback_ctrl
    import simon_pkg::*;
#(
    parameter int TICK_DIV    = 25_000_000,
    parameter int ON_TICKS    = 2,
    parameter int OFF_TICKS   = 1,
    parameter int ADDR_W      = 5,
    parameter int SPEEDUP_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   seq_len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic [3:0]        led_onehot,
    output logic              busy,
    output logic              done
);

    localparam int LW   = ADDR_W + 1;
    localparam int PMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int ON_H = ((ON_TICKS >> 1) < 1) ? 1 : (ON_TICKS >> 1);

    localparam logic [PW-1:0] ON_LAST   = PW'(ON_TICKS - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(ON_H - 1);
    localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_TICKS - 1);
    localparam logic [LW-1:0] MAX_LEN   = LW'(1 << ADDR_W);
    localparam logic [LW-1:0] SPD_LEN   = LW'(SPEEDUP_LEN);

`ifdef SIMON_SPEEDUP_EN
    localparam bit SPD_EN = 1'b1;
`else
    localparam bit SPD_EN = 1'b0;
`endif

    state_t            state, state_n;
    logic [LW-1:0]     len, len_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [ADDR_W-1:0] addr_n;
    logic [3:0]        led_n;
    logic [PW-1:0]     ph, ph_n;
    logic [PW-1:0]     on_last;
    logic              run, tick;

    assign run = (state == ST_ON) || (state == ST_GAP);

    simon_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!run),
        .en   (run),
        .tick (tick)
    );

    always_comb begin
        on_last = ON_LAST;
        if (SPD_EN && (len >= SPD_LEN)) begin
            on_last = FAST_LAST;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len;
        idx_n   = idx;
        addr_n  = rd_addr;
        led_n   = led_onehot;
        ph_n    = ph;
        if (abort && (state != ST_IDLE)) begin
            state_n = ST_IDLE;
            led_n   = 4'b0000;
            ph_n    = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_n   = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
                        idx_n   = '0;
                        addr_n  = '0;
                        ph_n    = '0;
                        state_n = (seq_len == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    led_n   = col_onehot(rd_data);
                    ph_n    = '0;
                    state_n = ST_ON;
                end
                ST_ON: begin
                    if (tick) begin
                        if (ph == on_last) begin
                            ph_n    = '0;
                            led_n   = 4'b0000;
                            state_n = ST_GAP;
                        end else begin
                            ph_n = ph + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (ph == OFF_LAST) begin
                            ph_n = '0;
                            if ({1'b0, idx} == len - 1'b1) begin
                                state_n = ST_DONE;
                            end else begin
                                idx_n   = idx + 1'b1;
                                addr_n  = rd_addr + 1'b1;
                                state_n = ST_FETCH;
                            end
                        end else begin
                            ph_n = ph + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    led_n   = 4'b0000;
                end
            endcase
        end
    end

    // done/busy are registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len        <= '0;
            idx        <= '0;
            rd_addr    <= '0;
            led_onehot <= 4'b0000;
            ph         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            len        <= len_n;
            idx        <= idx_n;
            rd_addr    <= addr_n;
            led_onehot <= led_n;
            ph         <= ph_n;
            busy       <= (state_n != ST_IDLE);
            done       <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_simon_playback_ctrl.sv
// Directed bench for simon_playback_ctrl: timing, len=0, abort, busy-start,
// TICK_DIV=1 full-length clamp and asynchronous reset.
module tb_simon_playback_ctrl;

`ifdef SIMON_SPEEDUP_EN
    localparam int ON_C = 4;
    localparam int FON  = 1;
`else
    localparam int ON_C = 12;
    localparam int FON  = 3;
`endif
    localparam int ABT = (ON_C > 5) ? 5 : ON_C - 1;
    localparam int FP  = FON + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic [3:0] seq_len = 4'd0;
    logic [2:0] rd_addr;
    logic [1:0] rd_data;
    logic [3:0] led;
    logic       busy, done;

    logic       f_start = 1'b0, f_abort = 1'b0;
    logic [3:0] f_len = 4'd0;
    logic [2:0] f_addr;
    logic [1:0] f_data;
    logic [3:0] f_led;
    logic       f_busy, f_done;

    logic [1:0] mem   [0:7];
    logic [1:0] f_mem [0:7];

    logic [3:0] tr_led  [0:127];
    logic [2:0] tr_addr [0:127];
    logic       tr_busy [0:127];
    logic       tr_done [0:127];

    int n_run = 0;
    int n_fail = 0;
    int dcnt, lit;

    always #5 clk = ~clk;

    // rd_addr is the RAM's registered address; read data follows it
    assign rd_data = mem[rd_addr];
    assign f_data  = f_mem[f_addr];

    simon_playback_ctrl #(
        .TICK_DIV(4), .ON_TICKS(3), .OFF_TICKS(2),
        .ADDR_W(3), .SPEEDUP_LEN(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seq_len(seq_len), .rd_addr(rd_addr), .rd_data(rd_data),
        .led_onehot(led), .busy(busy), .done(done)
    );

    simon_playback_ctrl #(
        .TICK_DIV(1), .ON_TICKS(3), .OFF_TICKS(2),
        .ADDR_W(3), .SPEEDUP_LEN(8)
    ) dut_f (
        .clk(clk), .rst_n(rst_n), .start(f_start), .abort(f_abort),
        .seq_len(f_len), .rd_addr(f_addr), .rd_data(f_data),
        .led_onehot(f_led), .busy(f_busy), .done(f_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cycle k is the cycle that begins at edge Ek; E0 samples start
    task automatic capture(input int n, input logic [3:0] len,
                           input int abt_at, input int rs_at);
        @(negedge clk);
        seq_len = len;
        start   = 1'b1;
        dcnt    = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            tr_led[k]  = led;
            tr_addr[k] = rd_addr;
            tr_busy[k] = busy;
            tr_done[k] = done;
            if (done) dcnt++;
            if (k == abt_at) abort = 1'b1;
            if (k == rs_at) begin
                start   = 1'b1;
                seq_len = 4'd5;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic capture_fast(input int n, input logic [3:0] len);
        @(negedge clk);
        f_len   = len;
        f_start = 1'b1;
        dcnt    = 0;
        lit     = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            f_start = 1'b0;
            tr_led[k]  = f_led;
            tr_addr[k] = f_addr;
            tr_busy[k] = f_busy;
            tr_done[k] = f_done;
            if (f_done) dcnt++;
            if (f_led != 4'd0) lit++;
        end
    endtask

    initial begin
        mem[0] = 2'd2;
        mem[1] = 2'd0;
        for (int i = 2; i < 8; i++) mem[i] = 2'd1;
        for (int i = 0; i < 8; i++) f_mem[i] = 2'(i % 4);

        #1;
        chk("rst_led", led, 4'd0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rd_addr, 0);
        #20 rst_n = 1'b1;

        capture(2 * ON_C + 22, 4'd2, -1, -1);
        chk("s1_fetch_led", tr_led[0], 4'd0);
        chk("s1_fetch_addr", tr_addr[0], 0);
        chk("s1_on1_first", tr_led[1], 4'b0100);
        chk("s1_on1_last", tr_led[ON_C], 4'b0100);
        chk("s1_gap1_first", tr_led[ON_C + 1], 4'd0);
        chk("s1_fetch2_led", tr_led[ON_C + 9], 4'd0);
        chk("s1_fetch2_addr", tr_addr[ON_C + 9], 1);
        chk("s1_on2_first", tr_led[ON_C + 10], 4'b0001);
        chk("s1_on2_last", tr_led[2 * ON_C + 9], 4'b0001);
        chk("s1_gap2_first", tr_led[2 * ON_C + 10], 4'd0);
        chk("s1_pre_done", tr_done[2 * ON_C + 17], 0);
        chk("s1_done", tr_done[2 * ON_C + 18], 1);
        chk("s1_busy_done", tr_busy[2 * ON_C + 18], 1);
        chk("s1_busy_end", tr_busy[2 * ON_C + 19], 0);
        chk("s1_done_cnt", dcnt, 1);

        capture(4, 4'd0, -1, -1);
        chk("s2_done", tr_done[0], 1);
        chk("s2_busy", tr_busy[0], 1);
        chk("s2_led", tr_led[0], 4'd0);
        chk("s2_busy_end", tr_busy[1], 0);
        chk("s2_done_end", tr_done[1], 0);

        capture(2 * ON_C + 22, 4'd2, ON_C + 9 + ABT, -1);
        chk("s3_lit_pre", tr_led[ON_C + 9 + ABT], 4'b0001);
        chk("s3_led_off", tr_led[ON_C + 10 + ABT], 4'd0);
        chk("s3_busy_off", tr_busy[ON_C + 10 + ABT], 0);
        chk("s3_no_done", dcnt, 0);
        chk("s3_addr_held", tr_addr[ON_C + 12 + ABT], 1);

        capture(2 * ON_C + 22, 4'd2, -1, 5);
        chk("s4_restart_addr", tr_addr[0], 0);
        chk("s4_on1_first", tr_led[1], 4'b0100);
        chk("s4_on2_first", tr_led[ON_C + 10], 4'b0001);
        chk("s4_done", tr_done[2 * ON_C + 18], 1);
        chk("s4_busy_end", tr_busy[2 * ON_C + 19], 0);
        chk("s4_done_cnt", dcnt, 1);

        capture_fast(8 * FP + 3, 4'd12);
        chk("s5_on0", tr_led[1], 4'b0001);
        chk("s5_on0_last", tr_led[FON], 4'b0001);
        chk("s5_gap0", tr_led[FON + 1], 4'd0);
        chk("s5_el3", tr_led[3 * FP + 1], 4'b1000);
        chk("s5_el7", tr_led[7 * FP + 1], 4'b1000);
        chk("s5_addr7", tr_addr[7 * FP], 7);
        chk("s5_done", tr_done[8 * FP], 1);
        chk("s5_busy_end", tr_busy[8 * FP + 1], 0);
        chk("s5_no_wrap", tr_addr[8 * FP + 1], 7);
        chk("s5_lit", lit, 8 * FON);
        chk("s5_done_cnt", dcnt, 1);

        capture(ON_C + 3, 4'd2, -1, -1);
        chk("s6_busy_pre", tr_busy[ON_C + 2], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_led", led, 4'd0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_done", done, 0);
        chk("s6_rst_addr", rd_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("s6_idle_busy", busy, 0);
        chk("s6_idle_led", led, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
